load_hazard_scoreboard: RTL and testbench

LOAD_HAZARD_SCOREBOARD -- requirements
Module: load_hazard_scoreboard

---
 rtl/load_hazard_scoreboard_if.sv | 28 ++
 rtl/load_hazard_scoreboard.sv | 87 ++++++++
 tb/tb_load_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_hazard_scoreboard_if.sv
// Handshake bundle between the ID/EX pipeline control and the load-use hazard scoreboard.
interface load_hazard_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2
);
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic                          ex_valid;
  logic                          ex_mem_read;
  logic [REG_ADDR_W-1:0]         ex_rd;
  logic                          flush;
  logic                          pc_write;
  logic                          if_id_write;
  logic                          id_ex_bubble;
  logic                          pending;
  logic [15:0]                   stall_cycles;

  modport master (
    output id_valid, id_rs, id_rs_used, ex_valid, ex_mem_read, ex_rd, flush,
    input  pc_write, if_id_write, id_ex_bubble, pending, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, ex_valid, ex_mem_read, ex_rd, flush,
    output pc_write, if_id_write, id_ex_bubble, pending, stall_cycles
  );
endinterface

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard detector: per-register countdown scoreboard that stalls ID readers
// of a load destination until the load result is available.
module load_hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  load_hazard_scoreboard_if.slave  bus
);
  localparam int unsigned NREG = 1 << REG_ADDR_W;
  localparam int unsigned CW   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int unsigned SW   = 16;
  localparam logic [CW-1:0] SET_VAL = CW'(LOAD_LAT - 1);

  logic                  ex_load;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic [REG_ADDR_W-1:0] src_addr;
  logic                  match;
  logic                  hazard;
  logic [SW-1:0]         stall_q;
  logic                  pending_q;

  assign ex_load = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != '0);

  // x0 is hardwired and never tracked
  assign busy[0]     = 1'b0;
  assign busy_nxt[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic          set;
    logic [CW-1:0] cnt_q;

    assign set = ex_load && (bus.ex_rd == REG_ADDR_W'(r));

    // a new load to the same register reloads the window rather than decrementing it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (set) begin
        cnt_q <= SET_VAL;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end

    assign busy[r]     = (cnt_q != '0);
    assign busy_nxt[r] = set ? (SET_VAL != '0) : (cnt_q > CW'(1));
  end

  // Any used, nonzero source hitting the load in EX or a still-counting register
  always_comb begin
    match    = 1'b0;
    src_addr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_addr = bus.id_rs[i*REG_ADDR_W +: REG_ADDR_W];
      if (bus.id_rs_used[i] && (src_addr != '0) &&
          ((ex_load && (bus.ex_rd == src_addr)) || busy[src_addr])) begin
        match = 1'b1;
      end
    end
  end

  // flush kills the ID instruction, so it must not stall, but issued loads keep counting
  assign hazard = rst_n & bus.id_valid & ~bus.flush & match;

  assign bus.pc_write     = ~hazard;
  assign bus.if_id_write  = ~hazard;
  assign bus.id_ex_bubble = hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= |busy_nxt;
      if (hazard && (stall_q != '1)) begin
        stall_q <= stall_q + SW'(1);
      end
    end
  end

  assign bus.pending      = pending_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Drives one stimulus stream into LOAD_LAT = 1, 3 and 4 instances and checks each against
// a load-window model every cycle, plus hand-computed literal pins.
module tb_load_hazard_scoreboard;
  localparam int unsigned AW   = 5;
  localparam int unsigned NS   = 2;
  localparam int unsigned NI   = 3;
  localparam int unsigned NREG = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0] id_rs_used;
  logic          ex_valid;
  logic          ex_mem_read;
  logic [AW-1:0] ex_rd;
  logic          flush;

  logic [NI-1:0]       pcw;
  logic [NI-1:0]       ifw;
  logic [NI-1:0]       bub;
  logic [NI-1:0]       pend;
  logic [NI-1:0][15:0] stc;

  int n_checks;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    load_hazard_scoreboard_if #(.REG_ADDR_W(AW), .NUM_SRC(NS)) bus ();

    assign bus.id_valid    = id_valid;
    assign bus.id_rs       = id_rs;
    assign bus.id_rs_used  = id_rs_used;
    assign bus.ex_valid    = ex_valid;
    assign bus.ex_mem_read = ex_mem_read;
    assign bus.ex_rd       = ex_rd;
    assign bus.flush       = flush;

    load_hazard_scoreboard #(
      .REG_ADDR_W(AW),
      .NUM_SRC   (NS),
      .LOAD_LAT  ((k == 0) ? 1 : ((k == 1) ? 3 : 4))
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    assign pcw[k]  = bus.pc_write;
    assign ifw[k]  = bus.if_id_write;
    assign bub[k]  = bus.id_ex_bubble;
    assign pend[k] = bus.pending;
    assign stc[k]  = bus.stall_cycles;
  end

  // ---------------- model: each load blocks its register for a time window ----------------
  int            last_load [NREG];
  int            exp_stall [NI];
  int            cyc;
  logic [NI-1:0] hz_s;
  logic          ld_s;
  logic [AW-1:0] rd_s;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // register r is still blocked at cycle c if a load to it was in EX within the last LAT-1 cycles
  function automatic bit blocked(input int r, input int k, input int c);
    return (r != 0) && (last_load[r] >= 0) && (last_load[r] < c) && (c < last_load[r] + lat_of(k));
  endfunction

  function automatic bit exp_hazard(input int k);
    bit ld;
    ld = ex_valid && ex_mem_read && (ex_rd != 0);
    if (!rst_n || !id_valid || flush) return 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      int a;
      a = int'(id_rs[i*AW +: AW]);
      if (id_rs_used[i] && (a != 0) && ((ld && (int'(ex_rd) == a)) || blocked(a, k, cyc)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_pending(input int k);
    if (!rst_n) return 1'b0;
    for (int r = 1; r < int'(NREG); r++)
      if (blocked(r, k, cyc)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string nm, input int k, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s inst%0d (LOAD_LAT=%0d) t=%0t: got %0d, expected %0d",
               nm, k, lat_of(k), $time, got, exp);
    end
  endtask

  initial begin
    for (int r = 0; r < int'(NREG); r++) last_load[r] = -1;
    for (int k = 0; k < int'(NI); k++) exp_stall[k] = 0;
    cyc  = 0;
    hz_s = '0;
    ld_s = 1'b0;
    rd_s = '0;
  end

  // compare on the falling edge, inputs and outputs settled
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREG); r++) last_load[r] = -1;
      for (int k = 0; k < int'(NI); k++) exp_stall[k] = 0;
    end
    for (int k = 0; k < int'(NI); k++) begin
      bit h;
      h = exp_hazard(k);
      hz_s[k] = h;
      check("pc_write",     k, int'(pcw[k]),  int'(!h));
      check("if_id_write",  k, int'(ifw[k]),  int'(!h));
      check("id_ex_bubble", k, int'(bub[k]),  int'(h));
      check("pending",      k, int'(pend[k]), int'(exp_pending(k)));
      check("stall_cycles", k, int'(stc[k]),  exp_stall[k]);
    end
    ld_s = rst_n && ex_valid && ex_mem_read && (ex_rd != 0);
    rd_s = ex_rd;
  end

  always @(posedge clk) begin
    if (ld_s) last_load[rd_s] = cyc;
    for (int k = 0; k < int'(NI); k++)
      if (hz_s[k] && exp_stall[k] != 65535) exp_stall[k]++;
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input int iv, input int r0, input int r1, input int used,
                        input int ev, input int em, input int rd, input int fl);
    id_valid    = (iv != 0);
    id_rs       = {AW'(r1), AW'(r0)};
    id_rs_used  = NS'(used);
    ex_valid    = (ev != 0);
    ex_mem_read = (em != 0);
    ex_rd       = AW'(rd);
    flush       = (fl != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int iv, input int r0, input int r1, input int used,
                      input int ev, input int em, input int rd, input int fl);
    set_in(iv, r0, r1, used, ev, em, rd, fl);
    tick();
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc_write", 1, int'(pcw[1]), 1);
    check("reset_stall",    2, int'(stc[2]), 0);
    rst_n = 1'b1;

    // load x5 in EX, ID reads x5 as source 0, then EX bubbles while the reader waits
    do_reset();
    set_in(1, 5, 0, 2'b01, 1, 1, 5, 0);
    #1;
    check("a_stall_pc_write", 0, int'(pcw[0]), 0);
    check("a_stall_bubble",   0, int'(bub[0]), 1);
    tick();
    set_in(1, 5, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("a_release",   0, int'(pcw[0]),  1);
    check("a_lat3_hold", 1, int'(pcw[1]),  0);
    check("a_lat3_pend", 1, int'(pend[1]), 1);
    tick();
    repeat (3) step(1, 5, 0, 2'b01, 0, 0, 0, 0);
    idle(1);
    check("a_total", 0, int'(stc[0]), 1);
    check("a_total", 1, int'(stc[1]), 3);
    check("a_total", 2, int'(stc[2]), 4);

    // load x7, reader on source 1
    do_reset();
    step(1, 0, 7, 2'b10, 1, 1, 7, 0);
    check("b_pend_after_load", 1, int'(pend[1]), 1);
    repeat (4) step(1, 0, 7, 2'b10, 0, 0, 0, 0);
    idle(1);
    check("b_total", 1, int'(stc[1]), 3);
    check("b_pend_drained", 1, int'(pend[1]), 0);

    // non-hazards: x0 load, invalid EX, non-load EX, unused source
    do_reset();
    step(1, 0, 0, 2'b11, 1, 1, 0, 0);
    step(1, 9, 0, 2'b01, 0, 1, 9, 0);
    step(1, 9, 0, 2'b01, 1, 0, 9, 0);
    step(1, 7, 3, 2'b10, 1, 1, 7, 0);
    idle(4);
    check("c_no_stall", 0, int'(stc[0]), 0);
    check("c_no_stall", 1, int'(stc[1]), 0);
    check("c_no_stall", 2, int'(stc[2]), 0);

    // flush on the first stall cycle, new reader arrives one cycle later
    do_reset();
    step(1, 7, 0, 2'b01, 1, 1, 7, 1);
    check("d_flush_no_stall", 1, int'(stc[1]), 0);
    repeat (4) step(1, 7, 0, 2'b01, 0, 0, 0, 0);
    idle(1);
    check("d_total", 0, int'(stc[0]), 0);
    check("d_total", 1, int'(stc[1]), 2);
    check("d_total", 2, int'(stc[2]), 3);

    // back-to-back loads to x3 reload the window
    do_reset();
    step(0, 0, 0, 2'b00, 1, 1, 3, 0);
    step(0, 0, 0, 2'b00, 1, 1, 3, 0);
    check("e_pend", 2, int'(pend[2]), 1);
    repeat (5) step(1, 3, 0, 2'b01, 0, 0, 0, 0);
    idle(1);
    check("e_total", 1, int'(stc[1]), 2);
    check("e_total", 2, int'(stc[2]), 3);

    // two sources waiting on two different loads
    do_reset();
    step(0, 0, 0, 2'b00, 1, 1, 4, 0);
    step(0, 0, 0, 2'b00, 1, 1, 6, 0);
    repeat (5) step(1, 4, 6, 2'b11, 0, 0, 0, 0);
    idle(1);
    check("f_total", 1, int'(stc[1]), 2);
    check("f_total", 2, int'(stc[2]), 3);

    // reset pulsed mid-stall
    do_reset();
    step(1, 7, 0, 2'b01, 1, 1, 7, 0);
    step(1, 7, 0, 2'b01, 0, 0, 0, 0);
    set_in(1, 7, 0, 2'b01, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("g_rst_pc_write", 1, int'(pcw[1]),  1);
    check("g_rst_if_id",    1, int'(ifw[1]),  1);
    check("g_rst_bubble",   1, int'(bub[1]),  0);
    check("g_rst_pending",  1, int'(pend[1]), 0);
    check("g_rst_stall",    1, int'(stc[1]),  0);
    tick();
    rst_n = 1'b1;
    set_in(1, 7, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("g_post_rst_pc_write", 1, int'(pcw[1]), 1);
    check("g_post_rst_pc_write", 2, int'(pcw[2]), 1);
    tick();
    step(1, 7, 0, 2'b01, 0, 0, 0, 0);
    idle(1);
    check("g_post_rst_stall", 1, int'(stc[1]), 0);
    check("g_post_rst_stall", 2, int'(stc[2]), 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
